// File: rtl/conv_window_buffer_pkg.sv
// Shared types and sizing helpers for the sliding-window line buffer.
package conv_win_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } win_state_t;

  // Width needed to hold value-1 as an index; never narrower than one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int calc_nbuf(input int ksize);
    return ksize + 1;
  endfunction

  function automatic int calc_w_out(input int img_width, input int ksize);
    return img_width - ksize + 1;
  endfunction

  localparam int DEF_IMG_WIDTH = 512;
  localparam int DEF_KSIZE     = 5;
  localparam int DEF_PIX_W     = 8;
  localparam int DEF_NBUF      = calc_nbuf(DEF_KSIZE);
  localparam int DEF_W_OUT     = calc_w_out(DEF_IMG_WIDTH, DEF_KSIZE);
  localparam int DEF_COL_W     = clog2(DEF_IMG_WIDTH);
  localparam int DEF_RCOL_W    = clog2(DEF_W_OUT);
  localparam int DEF_BUF_W     = clog2(DEF_NBUF);
  localparam int DEF_FILL_W    = clog2(DEF_NBUF + 1);

endpackage

// File: rtl/conv_window_buffer_line_ram.sv
// One image line of storage: single write port, KSIZE adjacent pixels read
// combinationally starting at a column address.
module line_ram
  import conv_win_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int KSIZE     = DEF_KSIZE,
  parameter int PIX_W     = DEF_PIX_W,
  parameter int AW        = clog2(IMG_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   we,
  input  logic [AW-1:0]          waddr,
  input  logic [PIX_W-1:0]       wdata,
  input  logic [AW-1:0]          raddr,
  output logic [KSIZE*PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // raddr never exceeds IMG_WIDTH-KSIZE, so raddr+gi stays inside the line.
  genvar gi;
  generate
    for (gi = 0; gi < KSIZE; gi++) begin : g_tap
      assign rdata[gi*PIX_W +: PIX_W] = mem[raddr + AW'(gi)];
    end
  endgenerate

endmodule

// File: rtl/conv_window_buffer.sv
// KSIZE x KSIZE sliding-window line buffer over a ring of KSIZE+1 line RAMs.
// Optional status ports (fill level, sticky overrun) under `define WIN_STATUS_EN.
module conv_window_buffer
  import conv_win_pkg::*;
#(
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int KSIZE     = DEF_KSIZE,
  parameter int PIX_W     = DEF_PIX_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [PIX_W-1:0]             i_pixel,
  input  logic                         i_pixel_valid,
  output logic                         o_pixel_ready,
  output logic [KSIZE*KSIZE*PIX_W-1:0] o_window,
  output logic                         o_window_valid,
  input  logic                         i_window_ready,
  output logic                         o_intr
`ifdef WIN_STATUS_EN
  ,
  output logic [$clog2(KSIZE+2)-1:0]   o_fill_level,
  output logic                         o_overrun
`endif
);

  localparam int NBUF   = calc_nbuf(KSIZE);
  localparam int W_OUT  = calc_w_out(IMG_WIDTH, KSIZE);
  localparam int COL_W  = clog2(IMG_WIDTH);
  localparam int RCOL_W = clog2(W_OUT);
  localparam int BUF_W  = clog2(NBUF);
  localparam int FILL_W = clog2(NBUF + 1);

  win_state_t        state_reg, state_next;
  logic [COL_W-1:0]  wr_col_reg;
  logic [RCOL_W-1:0] rd_col_reg;
  logic [BUF_W-1:0]  rd_base_reg;
  logic [FILL_W-1:0] lines_full_reg;
  logic              intr_reg;

  logic              pixel_ready;
  logic              accept;
  logic              line_done;
  logic              consume;
  logic              row_done;
  logic              win_valid;
  logic [FILL_W:0]   wr_sum;
  logic [BUF_W-1:0]  wr_buf;

  logic [KSIZE*PIX_W-1:0] ram_rdata [NBUF];

  always_comb begin
    pixel_ready = (lines_full_reg < FILL_W'(NBUF));
    accept      = i_pixel_valid && pixel_ready;
    line_done   = accept && (wr_col_reg == COL_W'(IMG_WIDTH - 1));
    consume     = (state_reg == ST_READ) && i_window_ready;
    row_done    = consume && (rd_col_reg == RCOL_W'(W_OUT - 1));
  end

  // The line being filled sits just past the complete, unreleased lines.
  always_comb begin
    wr_sum = (FILL_W+1)'(rd_base_reg) + (FILL_W+1)'(lines_full_reg);
    wr_buf = BUF_W'(wr_sum);
    if (wr_sum >= (FILL_W+1)'(NBUF)) wr_buf = BUF_W'(wr_sum - (FILL_W+1)'(NBUF));
  end

  always_comb begin
    state_next = state_reg;
    win_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (lines_full_reg >= FILL_W'(KSIZE)) state_next = ST_READ;
      end
      ST_READ: begin
        win_valid = 1'b1;
        if (row_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      wr_col_reg     <= '0;
      rd_col_reg     <= '0;
      rd_base_reg    <= '0;
      lines_full_reg <= '0;
      intr_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      intr_reg  <= row_done;
      if (accept) wr_col_reg <= line_done ? '0 : wr_col_reg + COL_W'(1);
      if (consume) rd_col_reg <= row_done ? '0 : rd_col_reg + RCOL_W'(1);
      if (row_done)
        rd_base_reg <= (rd_base_reg == BUF_W'(NBUF - 1)) ? '0 : rd_base_reg + BUF_W'(1);
      // A completed line and a released row on the same edge cancel out.
      case ({line_done, row_done})
        2'b10:   lines_full_reg <= lines_full_reg + FILL_W'(1);
        2'b01:   lines_full_reg <= lines_full_reg - FILL_W'(1);
        default: lines_full_reg <= lines_full_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NBUF; gi++) begin : g_ram
      line_ram #(
        .IMG_WIDTH (IMG_WIDTH),
        .KSIZE     (KSIZE),
        .PIX_W     (PIX_W),
        .AW        (COL_W)
      ) u_line_ram (
        .i_clk (i_clk),
        .we    (accept && (wr_buf == BUF_W'(gi))),
        .waddr (wr_col_reg),
        .wdata (i_pixel),
        .raddr (COL_W'(rd_col_reg)),
        .rdata (ram_rdata[gi])
      );
    end

    // Window row 0 is the oldest line, found at the ring base.
    for (gi = 0; gi < KSIZE; gi++) begin : g_row
      logic [BUF_W:0]   sel_sum;
      logic [BUF_W-1:0] sel;
      assign sel_sum = (BUF_W+1)'(rd_base_reg) + (BUF_W+1)'(gi);
      assign sel     = (sel_sum >= (BUF_W+1)'(NBUF)) ? BUF_W'(sel_sum - (BUF_W+1)'(NBUF))
                                                     : BUF_W'(sel_sum);
      assign o_window[gi*KSIZE*PIX_W +: KSIZE*PIX_W] = ram_rdata[sel];
    end
  endgenerate

  assign o_pixel_ready  = pixel_ready;
  assign o_window_valid = win_valid;
  assign o_intr         = intr_reg;

`ifdef WIN_STATUS_EN
  logic overrun_reg;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) overrun_reg <= 1'b0;
    else if (i_pixel_valid && !pixel_ready) overrun_reg <= 1'b1;
  end

  assign o_fill_level = lines_full_reg;
  assign o_overrun    = overrun_reg;
`endif

endmodule

// File: tb/tb_conv_window_buffer.sv
// Self-checking bench for conv_window_buffer (IMG_WIDTH=8, KSIZE=3, PIX_W=8):
// table-driven fill/first-row vectors, hand-written corner sequences, random traffic.
module tb_conv_window_buffer;

  localparam int IW = 8;
  localparam int K  = 3;
  localparam int PW = 8;
  localparam int NB = K + 1;
  localparam int WO = IW - K + 1;
  localparam int WB = K * K * PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pix = '0;
  logic          pv  = 1'b0;
  logic          wr  = 1'b0;
  logic          prdy;
  logic          wval;
  logic          intr;
  logic [WB-1:0] win;
`ifdef WIN_STATUS_EN
  logic [2:0]    fill;
  logic          ovr;
`endif

  always #5 clk = ~clk;

  conv_window_buffer #(
    .IMG_WIDTH (IW),
    .KSIZE     (K),
    .PIX_W     (PW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pixel        (pix),
    .i_pixel_valid  (pv),
    .o_pixel_ready  (prdy),
    .o_window       (win),
    .o_window_valid (wval),
    .i_window_ready (wr),
    .o_intr         (intr)
`ifdef WIN_STATUS_EN
    ,
    .o_fill_level   (fill),
    .o_overrun      (ovr)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of complete lines (oldest first), the partly
  // written line, and the output cursor of the row being emitted.
  logic [IW*PW-1:0] m_lines [$];
  logic [IW*PW-1:0] m_part;
  int               m_wcol;
  int               m_col;
  bit               m_valid;
  bit               m_intr;
  bit               m_overrun;

  task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  function automatic logic [WB-1:0] m_window();
    logic [WB-1:0]    w;
    logic [IW*PW-1:0] ln;
    w = '0;
    for (int r = 0; r < K; r++) begin
      if (r < m_lines.size()) begin
        ln = m_lines[r];
        for (int c = 0; c < K; c++) w[(r*K+c)*PW +: PW] = ln[(m_col+c)*PW +: PW];
      end
    end
    return w;
  endfunction

  // Window built from sequential pixel numbering: line L holds L*IW .. L*IW+IW-1.
  function automatic logic [WB-1:0] ref_win(input int line0, input int col);
    logic [WB-1:0] w;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*PW +: PW] = 8'((line0 + r) * IW + col + c);
    return w;
  endfunction

  task automatic model_clear();
    m_lines.delete();
    m_part    = '0;
    m_wcol    = 0;
    m_col     = 0;
    m_valid   = 1'b0;
    m_intr    = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Advance the model across one clock edge, then compare the DUT with it.
  task automatic tick();
    bit rdy, acc, cons, rel, start;
    rdy   = (m_lines.size() < NB);
    acc   = pv && rdy;
    cons  = m_valid && wr;
    rel   = cons && (m_col == WO - 1);
    start = !m_valid && (m_lines.size() >= K);
    if (pv && !rdy) m_overrun = 1'b1;
    m_intr = rel;
    if (cons) begin
      $display("window consumed: col %0d window %h", m_col, m_window());
      if (rel) begin
        void'(m_lines.pop_front());
        m_col   = 0;
        m_valid = 1'b0;
      end else begin
        m_col++;
      end
    end else if (start) begin
      m_valid = 1'b1;
    end
    if (acc) begin
      m_part[m_wcol*PW +: PW] = pix;
      if (m_wcol == IW - 1) begin
        m_lines.push_back(m_part);
        m_wcol = 0;
      end else begin
        m_wcol++;
      end
    end
    @(posedge clk);
    #1;
    chk("pixel_ready", prdy, (m_lines.size() < NB));
    chk("window_valid", wval, m_valid);
    chk("intr", intr, m_intr);
    if (m_valid) chk("window", win, m_window());
`ifdef WIN_STATUS_EN
    chk("fill_level", fill, WB'(m_lines.size()));
    chk("overrun", ovr, m_overrun);
`endif
  endtask

  // Raise reset between edges and check the outputs respond without a clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_pixel_ready", prdy, 1'b1);
    chk("rst_window_valid", wval, 1'b0);
    chk("rst_intr", intr, 1'b0);
`ifdef WIN_STATUS_EN
    chk("rst_fill_level", fill, '0);
    chk("rst_overrun", ovr, 1'b0);
`endif
    model_clear();
    pv = 1'b0;
    wr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit            pv;
    logic [PW-1:0] pix;
    bit            wr;
    bit            e_rdy;
    bit            e_val;
    bit            e_intr;
    logic [WB-1:0] e_win;
  } vec_t;

  vec_t tbl [32];

  task automatic run_table(input string tag);
    for (int i = 0; i < 32; i++) begin
      pv  = tbl[i].pv;
      pix = tbl[i].pix;
      wr  = tbl[i].wr;
      tick();
      chk($sformatf("%s[%0d].ready", tag, i), prdy, tbl[i].e_rdy);
      chk($sformatf("%s[%0d].valid", tag, i), wval, tbl[i].e_val);
      chk($sformatf("%s[%0d].intr", tag, i), intr, tbl[i].e_intr);
      if (tbl[i].e_val) chk($sformatf("%s[%0d].window", tag, i), win, tbl[i].e_win);
    end
    pv = 1'b0;
  endtask

  initial begin
    int p, n;
    bit r;

    // Pixels 0..23 fill three lines; windows appear one edge after the third
    // line completes, slide across six columns, then a one-cycle intr bubble.
    for (int i = 0; i < 32; i++) begin
      tbl[i].pv     = (i < 24);
      tbl[i].pix    = (i < 24) ? 8'(i) : 8'h00;
      tbl[i].wr     = 1'b1;
      tbl[i].e_rdy  = 1'b1;
      tbl[i].e_val  = (i >= 24) && (i <= 29);
      tbl[i].e_intr = (i == 30);
      tbl[i].e_win  = (i >= 24 && i <= 29) ? ref_win(0, i - 24) : '0;
    end

    model_clear();
    do_reset();
    run_table("fill");

    // Output stall at rd_col=2.
    do_reset();
    for (int t = 0; t < 24; t++) begin
      pv = 1'b1; pix = 8'(t); wr = 1'b1;
      tick();
    end
    pv = 1'b0;
    n = 0;
    while (!(wval && m_col == 2) && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("stall_reach");
    wr = 1'b0;
    repeat (5) begin
      tick();
      chk("stall_window", win, ref_win(0, 2));
      chk("stall_valid", wval, 1'b1);
    end
    wr = 1'b1;
    n = 0;
    while (!intr && n < 20) begin tick(); n++; end
    if (n >= 20) timeout("stall_intr");

    // Line completion coincides with the final window of row 0.
    do_reset();
    for (int t = 0; t < 33; t++) begin
      pv = (t <= 31); pix = 8'(t); wr = (t != 25);
      tick();
`ifdef WIN_STATUS_EN
      if (t == 30) chk("simul_fill_before", fill, 3'd3);
      if (t == 31) chk("simul_fill_after", fill, 3'd3);
`endif
      if (t == 31) chk("simul_intr", intr, 1'b1);
      if (t == 32) begin
        chk("simul_next_valid", wval, 1'b1);
        chk("simul_next_row", win, ref_win(1, 0));
      end
    end
    pv = 1'b0;
    repeat (6) tick();

    // Input full with output blocked, then overrun and a mid-row reset.
    do_reset();
    wr = 1'b0;
    p = 0;
    for (int i = 0; i < 40; i++) begin
      pv = 1'b1; pix = 8'(p);
      r = prdy;
      tick();
      if (r) begin
        p++;
        if (p == 32) chk("full_ready_low", prdy, 1'b0);
      end
    end
    chk("full_accepted", WB'(p), WB'(32));
    wr = 1'b1;
    n = 0;
    while (!intr && n < 20) begin
      pix = 8'(p); r = prdy;
      tick();
      if (r) p++;
      n++;
    end
    if (n >= 20) timeout("full_release");
    else chk("full_ready_back", prdy, 1'b1);
`ifdef WIN_STATUS_EN
    chk("overrun_set", ovr, 1'b1);
`endif
    n = 0;
    while (!(m_valid && m_col == 3) && n < 30) begin
      pix = 8'(p); r = prdy;
      tick();
      if (r) p++;
      n++;
    end
    if (n >= 30) timeout("midrow_reach");
`ifdef WIN_STATUS_EN
    chk("overrun_sticky", ovr, 1'b1);
`endif
    do_reset();
    run_table("refill");

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      pv  = ($urandom_range(0, 9) < 7);
      pix = 8'($urandom_range(0, 255));
      wr  = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
